// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing with a single registered output stage.
// Pixel colour, syncs and blank leave through the same pix_tick-enabled flops.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_tick,
  output logic       video_on,
  output logic       frame_start,
  input  logic [9:0] red_in,
  input  logic [9:0] green_in,
  input  logic [9:0] blue_in,
  output logic [9:0] vga_r,
  output logic [9:0] vga_g,
  output logic [9:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0]  X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] X_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] Y_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_LO  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_HI  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_LO  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_HI  = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit 10 bits");
  end
  if (H_VISIBLE < 1 || V_VISIBLE < 1 || H_SYNC < 1 || V_SYNC < 1)
  begin : g_bad_window
    $error("vga_timing_gen: visible and sync widths must be >= 1");
  end
  if (H_FRONT < 0 || H_BACK < 0 || V_FRONT < 0 || V_BACK < 0)
  begin : g_bad_porch
    $error("vga_timing_gen: porches must be non-negative");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic [9:0]       r_q, r_d;
  logic [9:0]       g_q, g_d;
  logic [9:0]       b_q, b_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_n_q, blank_n_d;
  logic             vclk_q, vclk_d;

  logic tick;
  logic x_last;
  logic y_last;
  logic von;
  logic hs_win;
  logic vs_win;

  always_comb begin
    tick   = (div_cnt_q == DIV_LAST);
    x_last = (x_q == X_LAST);
    y_last = (y_q == Y_LAST);
    von    = ({1'b0, x_q} < X_VIS) && ({1'b0, y_q} < Y_VIS);
    hs_win = ({1'b0, x_q} >= HS_LO) && ({1'b0, x_q} <= HS_HI);
    vs_win = ({1'b0, y_q} >= VS_LO) && ({1'b0, y_q} <= VS_HI);
  end

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_ONE;
    x_d       = x_q;
    y_d       = y_q;
    if (tick) begin
      x_d = x_last ? 10'd0 : x_q + 10'd1;
      if (x_last) begin
        y_d = y_last ? 10'd0 : y_q + 10'd1;
      end
    end
  end

  // Output stage advances only at the end of a pixel period.
  always_comb begin
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    if (tick) begin
      r_d       = von ? red_in   : 10'd0;
      g_d       = von ? green_in : 10'd0;
      b_d       = von ? blue_in  : 10'd0;
      hs_d      = ~hs_win;
      vs_d      = ~vs_win;
      blank_n_d = von;
    end
  end

  // With CLK_DIV=1 there is no divided clock; the board feeds the DAC from clk.
  always_comb begin
    vclk_d = 1'b0;
    if (CLK_DIV >= 2) begin
      vclk_d = (div_cnt_d >= DIV_HALF);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      r_q       <= 10'd0;
      g_q       <= 10'd0;
      b_q       <= 10'd0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      vclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      vclk_q    <= vclk_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pix_tick    = tick;
  assign video_on    = von;
  assign frame_start = tick & x_last & y_last;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b1;
  assign vga_clk     = vclk_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the system clock and drives the registered VGA output port. It sits directly upstream of the maze renderer: it supplies the pixel coordinates `x`/`y` that the renderer uses for square/path drawing and for its `y==481, x==0` refresh tick. It then takes the renderer's combinational `red`/`green`/`blue` back, blanks them, and registers them, hsync and vsync to the DAC pins.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (>=1)

Ports:
- clk  in  1  system clock (50 MHz nominal)
- reset  in  1  asynchronous, active-high
- x  out  10  current pixel column, 0..H_TOTAL-1
- y  out  10  current line, 0..V_TOTAL-1
- pix_tick  out  1  one-clk pulse on the last clk of each pixel period
- video_on  out  1  x<H_VISIBLE and y<V_VISIBLE (combinational from x,y)
- frame_start  out  1  one-clk pulse when counters wrap to (0,0)
- red_in, green_in, blue_in  in  10 each  pixel colour for current x,y
- vga_r, vga_g, vga_b  out  10 each  registered, blanked colour
- vga_hs, vga_vs  out  1 each  registered syncs, active-low
- vga_blank_n  out  1  registered video_on
- vga_sync_n  out  1  constant 1
- vga_clk  out  1  DAC pixel clock

## Operation
Totals and sync windows:
- H_TOTAL = sum of the H_* parameters = 800.
- V_TOTAL = sum of the V_* parameters = 525.
- hsync window: x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751].
- vsync window: y in [490,491].

Pixel divider:
- div_cnt counts 0..CLK_DIV-1 and wraps.
- pix_tick = (div_cnt == CLK_DIV-1).
- CLK_DIV=1 gives pix_tick constantly high.

Raster counters:
- On pix_tick: x increments; at x==H_TOTAL-1, x wraps to 0 and y increments.
- At y==V_TOTAL-1 with x wrapping, y wraps to 0.
- x and y hold for the whole pixel period, so a downstream refresh tick qualified with pix_tick fires exactly once per frame.

frame_start = pix_tick & (x==H_TOTAL-1) & (y==V_TOTAL-1).

Output stage: registered only on pix_tick.
- vga_r/g/b <= video_on ? *_in : 0.
- vga_hs <= ~hsync_window(x); vga_vs <= ~vsync_window(y).
- vga_blank_n <= video_on.

vga_clk:
- Registered: vga_clk <= (div_cnt_next >= CLK_DIV/2).
- Gives a rising edge mid-period for CLK_DIV>=2.
- CLK_DIV=1: vga_clk = ~clk gating is not allowed; drive vga_clk=0 and document that the board must use clk.

Parameter rules:
- Widths are fixed at 10 bits, so H_TOTAL and V_TOTAL must be <=1024.
- Out-of-range parameters are an elaboration error (assert).

## Timing
Reset values (asynchronous):
- div_cnt=0, x=0, y=0, pix_tick=0 (CLK_DIV>1).
- vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vga_sync_n=1, vga_clk=0.

Latency:
- Pixel outputs lag x/y by exactly one pixel period: colour for (x,y) appears at the pins after the pix_tick ending that pixel.
- Syncs and blank use the same single register stage, so they stay mutually aligned.

After reset deassert:
- First pix_tick occurs on clk edge CLK_DIV (counting the first post-reset edge as 1).
- x becomes 1 on that same edge.

Frame and line periods:
- Line = H_TOTAL*CLK_DIV clks = 1600.
- Frame = 800*525*2 = 840000 clks.

Boundary conditions:
- x wrap and y wrap happen on the same edge at the frame end.
- Reset mid-line or mid-frame returns everything to the reset values immediately; no partial pulses are generated afterwards.
- red_in etc. are sampled only at pix_tick; changes between ticks are ignored.

## Test plan
- Reset check: assert reset mid-frame at x=300, y=200 -> x=y=0, vga_hs=vga_vs=1, vga_r=0, vga_blank_n=0 within the same cycle. Release -> x=1 after exactly 2 clks.
- Line timing: over 3 lines -> x steps 0..799 and wraps, y increments at the wrap, 1600 clks/line. vga_hs low for exactly 192 clks, starting one pixel after x=656 is presented.
- Frame timing: over 2 frames -> vga_vs low for 3200 clks per frame, frame_start pulses once per 840000 clks, one clk wide. (x=0, y=481) is held for exactly 2 clks per frame.
- Blanking: red_in=green_in=blue_in=10'h3FF constant -> vga_r=3FF for pixels x 0..639, 0 for x 640..799 and for lines y>=480. vga_blank_n matches.
- Alignment: drive red_in=x -> at each pix_tick the registered vga_r equals the previous x, for all visible x.
- CLK_DIV=1 build: pix_tick constantly 1, line = 800 clks, frame = 420000 clks, vga_clk=0.
